y86_stage_sequencer: RTL and testbench

Y86_STAGE_SEQUENCER -- requirements
Module: y86_stage_sequencer

---
 rtl/y86_stage_sequencer.sv | 137 +++++++++++++
 tb/tb_y86_stage_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/y86_stage_sequencer.sv
// Multi-cycle Y86 stage sequencer: FETCH..PCUPDATE with data-memory handshake, HALT and FAULT.
// Optional perf counters (cycle_cnt, instr_cnt) enabled by defining Y86_SEQ_PERF_COUNTERS_EN.
module y86_stage_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        dmem_ack,
  output logic        f_en,
  output logic        d_en,
  output logic        e_en,
  output logic        m_en,
  output logic        w_en,
  output logic        dmem_req,
  output logic        pc_we,
`ifdef Y86_SEQ_PERF_COUNTERS_EN
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt,
`endif
  output logic [2:0]  stat
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_MEMORY,
    S_WRITEBACK,
    S_PCUPDATE,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      state_q;
  logic [3:0]  icode_q;
  logic [7:0]  wait_q;
  logic [2:0]  stat_q;
  logic        mem_op;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  always_comb begin
    mem_op = 1'b0;
    case (icode_q)
      4'd4, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11: mem_op = 1'b1;
      default:                              mem_op = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      icode_q <= '0;
      wait_q  <= '0;
      stat_q  <= STAT_AOK;
    end else begin
      case (state_q)
        S_FETCH: begin
          icode_q <= icode;
          if (imem_error) begin
            state_q <= S_FAULT;
            stat_q  <= STAT_ADR;
          end else if (icode > 4'd11) begin
            state_q <= S_FAULT;
            stat_q  <= STAT_INS;
          end else begin
            state_q <= S_DECODE;
          end
        end
        S_DECODE:  state_q <= S_EXECUTE;
        S_EXECUTE: begin
          state_q <= S_MEMORY;
          wait_q  <= '0;
        end
        S_MEMORY: begin
          if (!mem_op || dmem_ack) begin
            state_q <= S_WRITEBACK;
          end else if (wait_q == WAIT_LAST) begin
            // this cycle is the last one allowed; request drops with the state change
            state_q <= S_FAULT;
            stat_q  <= STAT_ADR;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        S_WRITEBACK: state_q <= S_PCUPDATE;
        S_PCUPDATE: begin
          if (icode_q == 4'd0) begin
            state_q <= S_HALT;
            stat_q  <= STAT_HLT;
          end else begin
            state_q <= S_FETCH;
            stat_q  <= STAT_AOK;
          end
        end
        S_HALT:  state_q <= S_HALT;
        S_FAULT: state_q <= S_FAULT;
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign f_en     = (state_q == S_FETCH);
  assign d_en     = (state_q == S_DECODE);
  assign e_en     = (state_q == S_EXECUTE);
  assign m_en     = (state_q == S_MEMORY);
  assign w_en     = (state_q == S_WRITEBACK);
  assign dmem_req = (state_q == S_MEMORY) && mem_op;
  assign pc_we    = (state_q == S_PCUPDATE);
  assign stat     = stat_q;

`ifdef Y86_SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt_q;
  logic [31:0] instr_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      if (state_q != S_HALT && state_q != S_FAULT) cycle_cnt_q <= cycle_cnt_q + 32'd1;
      if (state_q == S_PCUPDATE)                   instr_cnt_q <= instr_cnt_q + 32'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_y86_stage_sequencer.sv
// Directed bench for y86_stage_sequencer: stage order, memory wait/timeout, faults, halt, reset abort.
module tb_y86_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  icode = 4'd1;
  logic        imem_error = 1'b0;
  logic        dmem_ack = 1'b0;
  logic        f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we;
  logic [2:0]  stat;
`ifdef Y86_SEQ_PERF_COUNTERS_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  localparam logic [6:0] VF  = 7'b1000000;
  localparam logic [6:0] VD  = 7'b0100000;
  localparam logic [6:0] VE  = 7'b0010000;
  localparam logic [6:0] VM  = 7'b0001000;
  localparam logic [6:0] VMR = 7'b0001010;
  localparam logic [6:0] VW  = 7'b0000100;
  localparam logic [6:0] VP  = 7'b0000001;
  localparam logic [6:0] V0  = 7'b0000000;

  y86_stage_sequencer #(.MEM_TIMEOUT(15)) dut (
    .clk        (clk),
    .rst        (rst),
    .icode      (icode),
    .imem_error (imem_error),
    .dmem_ack   (dmem_ack),
    .f_en       (f_en),
    .d_en       (d_en),
    .e_en       (e_en),
    .m_en       (m_en),
    .w_en       (w_en),
    .dmem_req   (dmem_req),
    .pc_we      (pc_we),
`ifdef Y86_SEQ_PERF_COUNTERS_EN
    .cycle_cnt  (cycle_cnt),
    .instr_cnt  (instr_cnt),
`endif
    .stat       (stat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // outputs are sampled at the negedge, then the cycle is advanced
  task automatic step(input string tag, input logic [6:0] ev, input logic [2:0] es);
    check({tag, ".out"}, 32'({f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we}), 32'(ev));
    check({tag, ".stat"}, 32'(stat), 32'(es));
    @(negedge clk);
  endtask

  // leaves rst low at a negedge; the DUT is then in cycle 1 (FETCH)
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst.out", 32'({f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we}), 32'(VF));
    check("rst.stat", 32'(stat), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [6:0] nop_seq [6];
    logic [6:0] ld_seq [10];
    nop_seq = '{VF, VD, VE, VM, VW, VP};
    ld_seq  = '{VF, VD, VE, VMR, VMR, VMR, VMR, VW, VP, VF};

    // nop stream: pc_we on cycles 6, 12, 18
    icode = 4'd1;
    do_reset();
    for (int i = 0; i < 18; i++) step("nop", nop_seq[i % 6], 3'd1);
`ifdef Y86_SEQ_PERF_COUNTERS_EN
    check("perf.cycle", cycle_cnt, 32'd18);
    check("perf.instr", instr_cnt, 32'd3);
`endif

    // mrmovq with ack after 3 wait cycles
    icode = 4'd5;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      dmem_ack = (i == 6);
      step("ld", ld_seq[i], 3'd1);
    end
    dmem_ack = 1'b0;

    // rmmovq never acked: 15 request cycles then frozen FAULT
    icode = 4'd4;
    do_reset();
    step("to.f", VF, 3'd1);
    step("to.d", VD, 3'd1);
    step("to.e", VE, 3'd1);
    for (int i = 0; i < 15; i++) step("to.mem", VMR, 3'd1);
    for (int i = 0; i < 21; i++) step("to.fault", V0, 3'd3);

    // invalid icode, imem_error priority, icode boundary
    icode = 4'd13;
    do_reset();
    step("ins13.f", VF, 3'd1);
    step("ins13.fault", V0, 3'd4);
    step("ins13.hold", V0, 3'd4);
    icode = 4'd12;
    imem_error = 1'b1;
    do_reset();
    step("adr.f", VF, 3'd1);
    step("adr.fault", V0, 3'd3);
    imem_error = 1'b0;
    do_reset();
    step("ins12.f", VF, 3'd1);
    step("ins12.fault", V0, 3'd4);
    icode = 4'd11;
    do_reset();
    step("ic11.f", VF, 3'd1);
    step("ic11.d", VD, 3'd1);

    // halt completes once, then only reset exits
    icode = 4'd0;
    do_reset();
    for (int i = 0; i < 6; i++) step("halt.seq", nop_seq[i], 3'd1);
    icode = 4'd1;
    for (int i = 0; i < 3; i++) step("halt.hold", V0, 3'd2);
    rst = 1'b1;
    #1;
    check("halt.rst.out", 32'({f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we}), 32'(VF));
    check("halt.rst.stat", 32'(stat), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    step("halt.re.f", VF, 3'd1);
    step("halt.re.d", VD, 3'd1);

    // reset mid-MEMORY with outstanding request, late ack ignored
    icode = 4'd9;
    do_reset();
    step("ab.f", VF, 3'd1);
    step("ab.d", VD, 3'd1);
    step("ab.e", VE, 3'd1);
    step("ab.m1", VMR, 3'd1);
    check("ab.m2.out", 32'({f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we}), 32'(VMR));
    #2 rst = 1'b1;
    #1;
    check("ab.async.out", 32'({f_en, d_en, e_en, m_en, w_en, dmem_req, pc_we}), 32'(VF));
    check("ab.async.stat", 32'(stat), 32'd1);
    @(negedge clk);
    dmem_ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    icode = 4'd1;
    step("ab.re.f", VF, 3'd1);
    step("ab.re.d", VD, 3'd1);
    dmem_ack = 1'b0;
    for (int i = 2; i < 6; i++) step("ab.re", nop_seq[i], 3'd1);
    step("ab.re.f2", VF, 3'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
